// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the three-input mux scheduler.
package mux_sched_pkg;

  localparam int DATA_W           = 4;
  localparam int NREQ             = 3;
  localparam int HOLD_CYCLES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/mux_sched_rr_pick.sv
// Combinational round-robin picker: search starts just after the last grant, wrapping 2 -> 0.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_grant_i,
  output logic [NREQ-1:0] winner_o,
  output logic            found_o
);

  always_comb begin
    winner_o = '0;
    found_o  = |req_i;
    case (last_grant_i)
      2'd0: begin
        if      (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) winner_o = 3'b100;
        else if (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) winner_o = 3'b001;
        else if (req_i[1]) winner_o = 3'b010;
        else if (req_i[2]) winner_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mux_sched.sv
// Round-robin 3:1 mux scheduler with bounded hold and a one-cycle break-before-make gap.
// Define MUX_SCHED_ASSERT_EN to compile in protocol assertions.
//
// state | meaning
// IDLE  | no requester granted, arbitrate on any req
// GRANT | one sel high, data forwarded to mux_op each edge
// GAP   | all sels low for one cycle, then re-arbitrate or go IDLE
module mux_sched
  import mux_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] ip1,
  input  logic [DATA_W-1:0] ip2,
  input  logic [DATA_W-1:0] ip3,
  output logic              sel1,
  output logic              sel2,
  output logic              sel3,
  output logic [DATA_W-1:0] mux_op,
  output logic              op_valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [DATA_W-1:0] mux_q, mux_d;
  logic              valid_q, valid_d;

  logic [NREQ-1:0]   winner;
  logic              found;
  logic [DATA_W-1:0] sel_data;

  rr_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .winner_o     (winner),
    .found_o      (found)
  );

  assign sel_data = ({DATA_W{sel_q[0]}} & ip1)
                  | ({DATA_W{sel_q[1]}} & ip2)
                  | ({DATA_W{sel_q[2]}} & ip3);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    mux_d   = mux_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          cnt_d   = 4'(HOLD_CYCLES - 1);
          last_d  = oh2idx(winner);
        end else begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      GRANT: begin
        valid_d = 1'b1;
        mux_d   = sel_data;
        // Owner dropping its request ends the grant early.
        if (cnt_q == 4'd0 || (req & sel_q) == '0) begin
          state_d = GAP;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= 4'd0;
      last_q  <= 2'd2;
      mux_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      mux_q   <= mux_d;
      valid_q <= valid_d;
    end
  end

  assign sel1     = sel_q[0];
  assign sel2     = sel_q[1];
  assign sel3     = sel_q[2];
  assign mux_op   = mux_q;
  assign op_valid = valid_q;
  assign busy     = (state_q == GRANT);

`ifdef MUX_SCHED_ASSERT_EN
  logic [4:0] run_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               run_q <= 5'd0;
    else if (state_q == GRANT)  run_q <= run_q + 5'd1;
    else                        run_q <= 5'd0;
  end

  a_sel_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(sel_q));
  a_gap_zero: assert property (@(posedge clock) disable iff (!reset_n)
    (state_q == GAP) |-> (sel_q == '0));
  a_grant_len: assert property (@(posedge clock) disable iff (!reset_n)
    run_q <= 5'(HOLD_CYCLES));
  a_grant_req: assert property (@(posedge clock) disable iff (!reset_n)
    (state_q != GRANT && state_d == GRANT) |-> ((req & sel_d) != '0));
  a_valid_busy: assert property (@(posedge clock) disable iff (!reset_n)
    op_valid |-> $past(busy));
`else
`endif

endmodule

// File: tb/tb_mux_sched.sv
// Self-checking bench for mux_sched: fixed vectors, hand sequences, random vs. a cycle model.
module tb_mux_sched;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] req_a, req_b;
  logic [3:0] ipa0, ipa1, ipa2, ipb0, ipb1, ipb2;
  logic [2:0] sel_a, sel_b;
  logic [3:0] mux_a, mux_b;
  logic       val_a, val_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mux_sched #(.HOLD_CYCLES(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .req(req_a),
    .ip1(ipa0), .ip2(ipa1), .ip3(ipa2),
    .sel1(sel_a[0]), .sel2(sel_a[1]), .sel3(sel_a[2]),
    .mux_op(mux_a), .op_valid(val_a), .busy(busy_a)
  );

  mux_sched #(.HOLD_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req(req_b),
    .ip1(ipb0), .ip2(ipb1), .ip3(ipb2),
    .sel1(sel_b[0]), .sel2(sel_b[1]), .sel3(sel_b[2]),
    .mux_op(mux_b), .op_valid(val_b), .busy(busy_b)
  );

  // Model: owner index (-1 none), cycles held so far, last winner.
  int         m_owner[2];
  int         m_held[2];
  int         m_last[2];
  logic [3:0] m_mux[2];
  logic       m_valid[2];

  typedef struct {
    logic [2:0] req;
    logic [2:0] sel;
    logic [3:0] mux;
    logic       v;
    logic       b;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_held[k] = 0; m_last[k] = 2; m_mux[k] = 4'd0; m_valid[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int hold, input logic [2:0] r,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] x[3];
    bit found;
    x[0] = a; x[1] = b; x[2] = c;
    if (m_owner[k] >= 0) begin
      m_valid[k] = 1'b1;
      m_mux[k]   = x[m_owner[k]];
      m_held[k]++;
      if (m_held[k] >= hold || !r[m_owner[k]]) m_owner[k] = -1;
    end else begin
      m_valid[k] = 1'b0;
      found = 0;
      for (int i = 1; i <= 3; i++) begin
        int j;
        j = (m_last[k] + i) % 3;
        if (!found && r[j]) begin
          found = 1; m_owner[k] = j;
        end
      end
      if (found) begin
        m_last[k] = m_owner[k];
        m_held[k] = 0;
      end
    end
  endtask

  function automatic logic [2:0] exp_sel(input int k);
    return (m_owner[k] >= 0) ? 3'(1 << m_owner[k]) : 3'b000;
  endfunction

  task automatic cycle();
    model_step(0, 2, req_a, ipa0, ipa1, ipa2);
    model_step(1, 1, req_b, ipb0, ipb1, ipb2);
    @(posedge clock);
    @(negedge clock);
    check("h2_sel",   32'(sel_a),  32'(exp_sel(0)));
    check("h2_mux",   32'(mux_a),  32'(m_mux[0]));
    check("h2_valid", 32'(val_a),  32'(m_valid[0]));
    check("h2_busy",  32'(busy_a), 32'(m_owner[0] >= 0));
    check("h1_sel",   32'(sel_b),  32'(exp_sel(1)));
    check("h1_mux",   32'(mux_b),  32'(m_mux[1]));
    check("h1_valid", 32'(val_b),  32'(m_valid[1]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    req_a = 3'b000; req_b = 3'b111;
    ipa0 = 4'h1; ipa1 = 4'h2; ipa2 = 4'h4;
    ipb0 = 4'h8; ipb1 = 4'h9; ipb2 = 4'hA;
    model_reset();

    // req=111 rotation, HOLD=2: 2-cycle grants with one zero-sel gap between.
    tbl[0]  = '{3'b111, 3'b001, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{3'b111, 3'b001, 4'h1, 1'b1, 1'b1};
    tbl[2]  = '{3'b111, 3'b000, 4'h1, 1'b1, 1'b0};
    tbl[3]  = '{3'b111, 3'b010, 4'h1, 1'b0, 1'b1};
    tbl[4]  = '{3'b111, 3'b010, 4'h2, 1'b1, 1'b1};
    tbl[5]  = '{3'b111, 3'b000, 4'h2, 1'b1, 1'b0};
    tbl[6]  = '{3'b111, 3'b100, 4'h2, 1'b0, 1'b1};
    tbl[7]  = '{3'b111, 3'b100, 4'h4, 1'b1, 1'b1};
    tbl[8]  = '{3'b111, 3'b000, 4'h4, 1'b1, 1'b0};
    tbl[9]  = '{3'b111, 3'b001, 4'h4, 1'b0, 1'b1};
    tbl[10] = '{3'b111, 3'b001, 4'h1, 1'b1, 1'b1};
    tbl[11] = '{3'b111, 3'b000, 4'h1, 1'b1, 1'b0};

    @(negedge clock);
    @(negedge clock);
    check("rst_sel",   32'(sel_a),  32'h0);
    check("rst_mux",   32'(mux_a),  32'h0);
    check("rst_valid", 32'(val_a),  32'h0);
    check("rst_busy",  32'(busy_a), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      req_a = tbl[i].req;
      cycle();
      check($sformatf("tbl%0d_sel", i),   32'(sel_a),  32'(tbl[i].sel));
      check($sformatf("tbl%0d_mux", i),   32'(mux_a),  32'(tbl[i].mux));
      check($sformatf("tbl%0d_valid", i), 32'(val_a),  32'(tbl[i].v));
      check($sformatf("tbl%0d_busy", i),  32'(busy_a), 32'(tbl[i].b));
    end

    // Single requester: 2-cycle grant, gap, re-grant to ip1.
    req_a = 3'b000;
    do_reset();
    req_a = 3'b001; ipa0 = 4'h1;
    cycle(); cycle(); cycle();
    check("solo_gap_sel", 32'(sel_a), 32'h0);
    cycle();
    check("solo_regrant", 32'(sel_a), 32'h1);

    // Early drop: req[1] released after the first grant cycle.
    req_a = 3'b000;
    do_reset();
    req_a = 3'b010; ipa1 = 4'h6;
    cycle();
    check("drop_sel2", 32'(sel_a), 32'h2);
    req_a = 3'b000;
    cycle();
    check("drop_gap_sel",  32'(sel_a), 32'h0);
    check("drop_valid",    32'(val_a), 32'h1);
    check("drop_mux",      32'(mux_a), 32'h6);
    cycle();
    check("drop_idle_valid", 32'(val_a), 32'h0);
    check("drop_idle_busy",  32'(busy_a), 32'h0);

    // Async reset in the middle of an ip3 grant.
    do_reset();
    req_a = 3'b100; ipa2 = 4'h9;
    cycle(); cycle();
    check("mid_mux_pre", 32'(mux_a), 32'h9);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sel",   32'(sel_a),  32'h0);
    check("mid_rst_mux",   32'(mux_a),  32'h0);
    check("mid_rst_valid", 32'(val_a),  32'h0);
    check("mid_rst_busy",  32'(busy_a), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    req_a = 3'b101;
    cycle();
    check("mid_after_ip1", 32'(sel_a), 32'h1);

    // HOLD=1 rotation with req=111 on the second instance.
    req_a = 3'b000; req_b = 3'b111;
    do_reset();
    cycle(); check("h1_rot0", 32'(sel_b), 32'h1);
    cycle(); check("h1_gap0", 32'(sel_b), 32'h0);
    cycle(); check("h1_rot1", 32'(sel_b), 32'h2);
    cycle(); cycle(); check("h1_rot2", 32'(sel_b), 32'h4);

    for (int n = 0; n < 400; n++) begin
      req_a = 3'($urandom_range(0, 7));
      req_b = 3'($urandom_range(0, 7));
      ipa0 = 4'($urandom); ipa1 = 4'($urandom); ipa2 = 4'($urandom);
      ipb0 = 4'($urandom); ipb1 = 4'($urandom); ipb2 = 4'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
